// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two line buffers, loadable signed kernel,
// shift-normalise and saturate, valid/ready on both sides.
module conv3x3_stream #(
  parameter int DW    = 8,
  parameter int KW    = 8,
  parameter int OW    = 20,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int SHIFT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [9*KW-1:0] kernel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data,
  output logic            busy,
  output logic            done
);

  localparam int PW = DW + KW + 1;
  localparam int SW = DW + KW + 5;
  localparam int XW = ((SW > OW) ? SW : OW) + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic signed [XW-1:0] OMAX =
    {{(XW-OW){1'b0}}, {OW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic signed [KW-1:0] kern_q [9];
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  logic [DW-1:0] win_q [3][3];
  logic signed [PW-1:0] prod_q [9];
  logic v0_q, v1_q, ov_q;
  logic [OW-1:0] od_q;

  logic stall, acc, start_ok, last_px, win_ok;
  logic signed [SW-1:0] sum, shr;
  logic signed [XW-1:0] shx;
  logic [OW-1:0] sat;

  assign stall    = ov_q & ~out_ready;
  assign in_ready = (state_q == RUN) & ~stall;
  assign acc      = in_valid & in_ready;
  assign start_ok = start & (state_q == IDLE);
  assign last_px  = (row_q == RW'(IMG_H-1))
                  & (col_q == CW'(IMG_W-1));
  assign win_ok   = (row_q >= RW'(2))
                  & (col_q >= CW'(2));

  assign out_valid = ov_q;
  assign out_data  = od_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (acc && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!v0_q && !v1_q && (!ov_q || out_ready))
          state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i < 9; i++) kern_q[i] <= '0;
    end else if (start_ok) begin
      col_q <= '0;
      row_q <= '0;
      for (int i = 0; i < 9; i++)
        kern_q[i] <= kernel[(9-i)*KW-1 -: KW];
    end else if (acc) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_q <= '0;
        row_q <= last_px ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // lb0 holds the previous row, lb1 the one before it
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0_q[col_q] <= in_data;
      lb1_q[col_q] <= lb0_q[col_q];
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_q[col_q];
      win_q[1][2] <= lb0_q[col_q];
      win_q[2][2] <= in_data;
    end
    if (!stall) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          prod_q[r*3+c] <= PW'(
            $signed({1'b0, win_q[r][c]}) * kern_q[r*3+c]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 9; i++)
      sum = sum + SW'(prod_q[i]);
    shr = sum >>> SHIFT;
    shx = XW'(shr);
    if (shx[XW-1])      sat = '0;
    else if (shx > OMAX) sat = '1;
    else                sat = shx[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
    end else if (!stall) begin
      v0_q <= acc & win_ok;
      v1_q <= v0_q;
      ov_q <= v1_q;
      if (v1_q) od_q <= sat;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x6 frame,
// one instance per normalising shift (4 and 0).
module tb_conv3x3_stream;

  logic        clk;
  logic        rst;
  logic        start;
  logic [71:0] kernel;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        ir0, ov0, bz0, dn0;
  logic        ir1, ov1, bz1, dn1;
  logic [15:0] od0, od1;

  int checks   = 0;
  int failures = 0;

  localparam logic [71:0] K_SM =
    {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
  localparam logic [71:0] K_NEG =
    {8'd0, 8'd0, 8'd0, 8'd0, 8'hF8, 8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [71:0] K_MAX = {9{8'd127}};

  conv3x3_stream #(
    .DW(8), .KW(8), .OW(16), .IMG_W(8), .IMG_H(6), .SHIFT(4)
  ) u0 (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .busy(bz0), .done(dn0)
  );

  conv3x3_stream #(
    .DW(8), .KW(8), .OW(16), .IMG_W(8), .IMG_H(6), .SHIFT(0)
  ) u1 (
    .clk(clk), .rst(rst), .start(start), .kernel(kernel),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .busy(bz1), .done(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // mode: 0 flat, 1 ramp, 2 negative clamp, 3 saturation
  function automatic logic [7:0] pix(input int mode,
                                     input int p);
    case (mode)
      0:       return 8'd10;
      1:       return 8'(p);
      2:       return 8'd5;
      default: return 8'd255;
    endcase
  endfunction

  function automatic int expv(input int mode, input int k);
    int r, c;
    r = 1 + k / 6;
    c = 1 + k % 6;
    case (mode)
      0:       return 10;
      1:       return 8 * r + c;
      2:       return 0;
      default: return 65535;
    endcase
  endfunction

  task automatic run_frame(input int mode,
                           input logic [71:0] kern,
                           input bit sel,
                           input bit rnd,
                           input int abort_at,
                           input bit inj);
    int p, k, dones, first_ov, acc22, last_out, done_cyc;
    bit prev_stall;
    logic [15:0] prev_od, od;
    logic ov, ir, dn, bz;
    p = 0; k = 0; dones = 0;
    first_ov = -1; acc22 = -1;
    last_out = -100; done_cyc = 0;
    prev_stall = 0; prev_od = '0;
    @(negedge clk);
    start = 1'b1;
    kernel = kern;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_start", sel ? bz1 : bz0, 1);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid = (p < 48) && (!rnd || $urandom_range(0, 1) == 1);
      in_data = pix(mode, p);
      out_ready = !rnd || ($urandom_range(0, 3) != 0);
      start = inj && (cyc == 10);
      if (start) kernel = '0;
      #1;
      ov = sel ? ov1 : ov0;
      od = sel ? od1 : od0;
      ir = sel ? ir1 : ir0;
      dn = sel ? dn1 : dn0;
      bz = sel ? bz1 : bz0;
      if (prev_stall) begin
        check("hold_valid", ov, 1);
        check("hold_data", od, prev_od);
      end
      if (ov && !out_ready) check("stall_ready", ir, 0);
      if (dn) begin
        dones++;
        if (dones == 1) begin
          done_cyc = cyc;
          check("done_lat", cyc, last_out + 1);
          check("busy_at_done", bz, 0);
        end
      end
      if (ov && first_ov < 0) first_ov = cyc;
      if (ov && out_ready) begin
        check("out_data", od, expv(mode, k));
        k++;
        last_out = cyc;
      end
      if (in_valid && ir) begin
        if (p == 18) acc22 = cyc;
        p++;
      end
      prev_stall = ov && !out_ready;
      prev_od = od;
      if (abort_at > 0 && p == abort_at) break;
      if (dones > 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at > 0) begin
      check("abort_px", p, abort_at);
    end else begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("n_out", k, 24);
      check("n_done", dones, 1);
      if (!rnd && mode == 1)
        check("lat_first", first_ov - (acc22 + 1), 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    kernel = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", ir0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_out_data", od0, 0);
    check("rst_busy", bz0, 0);
    check("rst_done", dn0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, K_SM, 1'b0, 1'b0, 0, 1'b0);
    run_frame(1, K_SM, 1'b0, 1'b0, 0, 1'b0);
    run_frame(2, K_NEG, 1'b1, 1'b0, 0, 1'b0);
    run_frame(3, K_MAX, 1'b1, 1'b0, 0, 1'b0);
    run_frame(0, K_SM, 1'b0, 1'b1, 0, 1'b0);
    run_frame(1, K_SM, 1'b0, 1'b1, 0, 1'b0);

    run_frame(0, K_SM, 1'b0, 1'b0, 20, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", ir0, 0);
    check("abort_out_valid", ov0, 0);
    check("abort_busy", bz0, 0);
    check("abort_done", dn0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", dn0, 0);
    end

    run_frame(0, K_SM, 1'b0, 1'b0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
